// File: rtl/histogram_engine.sv
// Streaming histogram: one sample per cycle bumps a saturating bin counter via a
// forwarded 2-stage read-modify-write; bins are zeroed by a sweep after reset or CLR.
module histogram_engine #(
    parameter  int BINS  = 128,
    parameter  int CNT_W = 16,
    localparam int ADR_W = $clog2(BINS)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   CLR,
    input  logic                   s_valid,
    input  logic [ADR_W-1:0]       s_data,
    output logic                   s_ready,
    input  logic                   rd_req,
    input  logic [ADR_W-1:0]       rd_addr,
    output logic                   rd_valid,
    output logic [CNT_W-1:0]       rd_data,
    output logic                   busy,
    output logic                   sat,
    output logic [CNT_W+ADR_W-1:0] total
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                   r_state, w_state_nxt;
    logic [ADR_W-1:0]         r_swp, w_swp_nxt;
    logic [CNT_W-1:0]         r_mem [BINS];

    logic [CNT_W-1:0]         r_q;
    logic                     r_s2_vld;
    logic [ADR_W-1:0]         r_s2_addr;
    logic                     r_rd_vld;
    logic                     r_sat;
    logic [CNT_W+ADR_W-1:0]   r_total;

    logic                     w_run, w_acc, w_rd_acc, w_s2_we, w_s2_max, w_s2_fwd;
    logic [ADR_W-1:0]         w_raddr;
    logic [CNT_W-1:0]         w_s2_new;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_CLEAR;
            r_swp   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_swp   <= w_swp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_swp_nxt   = r_swp;
        if (CLR) begin
            w_state_nxt = ST_CLEAR;
            w_swp_nxt   = '0;
        end else if (r_state == ST_CLEAR) begin
            w_swp_nxt = r_swp + 1'b1;
            if (r_swp == ADR_W'(BINS - 1)) w_state_nxt = ST_RUN;
        end
    end

    assign w_run    = (r_state == ST_RUN);
    assign s_ready  = w_run && !CLR && !rd_req;
    assign w_acc    = s_valid && s_ready;
    assign w_rd_acc = w_run && rd_req && !CLR;

    // Readout and samples never issue together, so they share one read port.
    assign w_raddr  = rd_req ? rd_addr : s_data;
    assign w_s2_max = &r_q;
    assign w_s2_new = w_s2_max ? r_q : r_q + 1'b1;
    assign w_s2_we  = r_s2_vld && !CLR;
    assign w_s2_fwd = r_s2_vld && (r_s2_addr == w_raddr);

    always_ff @(posedge CLK) begin
        if (r_state == ST_CLEAR)
            r_mem[r_swp] <= '0;
        else if (w_s2_we)
            r_mem[r_s2_addr] <= w_s2_new;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_q       <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_rd_vld  <= 1'b0;
            r_sat     <= 1'b0;
            r_total   <= '0;
        end else begin
            r_s2_vld  <= w_acc;
            r_s2_addr <= s_data;
            r_rd_vld  <= w_rd_acc;
            // The stage-2 value lands in the array this same edge, so bypass it.
            if (w_acc || w_rd_acc)
                r_q <= w_s2_fwd ? w_s2_new : r_mem[w_raddr];
            if (CLR) begin
                r_sat   <= 1'b0;
                r_total <= '0;
            end else begin
                if (w_s2_we && w_s2_max) r_sat <= 1'b1;
                if (w_acc && !(&r_total)) r_total <= r_total + 1'b1;
            end
        end
    end

    assign rd_valid = r_rd_vld;
    assign rd_data  = r_q;
    assign busy     = (r_state == ST_CLEAR);
    assign sat      = r_sat;
    assign total    = r_total;

endmodule

// File: tb/tb_histogram_engine.sv
// Scoreboarded bench for histogram_engine: directed scenarios plus random traffic
// against an array-based histogram model; a monitor checks every readout.
module tb_histogram_engine;
    localparam int BINS  = 128;
    localparam int CNT_W = 4;
    localparam int ADR_W = 7;
    localparam int TW    = CNT_W + ADR_W;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int TMAX  = (1 << TW) - 1;

    logic             CLK = 1'b0, RST_N = 1'b0, CLR = 1'b0, s_valid = 1'b0, rd_req = 1'b0;
    logic [ADR_W-1:0] s_data = '0, rd_addr = '0;
    logic             s_ready, rd_valid, busy, sat;
    logic [CNT_W-1:0] rd_data;
    logic [TW-1:0]    total;

    histogram_engine #(.BINS(BINS), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .busy(busy), .sat(sat), .total(total)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {int due; int val; int addr;} rd_t;
    rd_t q[$];
    rd_t mon_e;

    int mdl [BINS];
    int mtot, msat, clr_left;
    int n_total = 0, n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        foreach (mdl[i]) mdl[i] = 0;
        mtot = 0;
        msat = 0;
        clr_left = BINS;
    endtask

    // One clock of stimulus; the model advances by what the histogram should do with it.
    task automatic step(input bit v, input int d, input bit r, input int ra, input bit c);
        bit exp_rdy;
        s_valid = v; s_data = ADR_W'(d); rd_req = r; rd_addr = ADR_W'(ra); CLR = c;
        @(negedge CLK);
        exp_rdy = (clr_left == 0) && !c && !r;
        chk("busy", busy, clr_left > 0);
        chk("s_ready", s_ready, exp_rdy);
        if (c) model_clear();
        else if (clr_left > 0) clr_left--;
        else if (r) q.push_back('{cyc + 1, mdl[ra], ra});
        else if (v) begin
            if (mdl[d] == MAXC) msat = 1;
            else mdl[d]++;
            if (mtot < TMAX) mtot++;
        end
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic wait_sweep();
        while (clr_left > 0) step(0, 0, 0, 0, 0);
    endtask

    task automatic status();
        idle(2);
        chk("sat", sat, msat);
        chk("total", total, mtot);
    endtask

    task automatic do_reset(input int hold);
        RST_N = 1'b0; s_valid = 1'b0; rd_req = 1'b0; CLR = 1'b0;
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_sat", sat, 0);
        chk("rst_total", total, 0);
        q.delete();
        model_clear();
        repeat (hold) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            if (rd_valid) begin
                if (q.size() == 0) chk("rd_spurious", rd_valid, 0);
                else begin
                    mon_e = q.pop_front();
                    chk("rd_latency", cyc, mon_e.due);
                    chk($sformatf("rd_data[%0d]", mon_e.addr), rd_data, mon_e.val);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk("rd_missing", rd_valid, 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        do_reset(3);
        wait_sweep();
        step(0, 0, 1, 0, 0); step(0, 0, 1, 64, 0); step(0, 0, 1, 127, 0);
        idle(2);

        repeat (5) step(1, 3, 0, 0, 0);
        step(0, 0, 1, 3, 0); step(0, 0, 1, 2, 0); step(0, 0, 1, 4, 0);
        status();

        step(0, 0, 0, 0, 1);
        wait_sweep();
        repeat (17) step(1, 9, 0, 0, 0);
        step(0, 0, 1, 9, 0);
        status();

        step(1, 7, 0, 0, 0);
        step(1, 7, 1, 7, 0);
        status();

        step(1, 10, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        wait_sweep();
        step(0, 0, 1, 10, 0);
        status();

        for (int i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 99);
            if (op < 55)      step(1, $urandom_range(0, 15), 0, 0, 0);
            else if (op < 80) step($urandom_range(0, 1), $urandom_range(0, 15), 1,
                                   $urandom_range(0, BINS - 1), 0);
            else if (op < 81) step($urandom_range(0, 1), $urandom_range(0, 15), 0, 0, 1);
            else              step(0, 0, 0, 0, 0);
        end
        wait_sweep();
        status();
        for (int a = 0; a < BINS; a++) step(0, 0, 1, a, 0);
        idle(2);

        do_reset(2);
        idle(50);
        do_reset(3);
        wait_sweep();
        repeat (3) step(1, 50, 0, 0, 0);
        step(0, 0, 1, 50, 0); step(0, 0, 1, 0, 0);
        status();

        idle(3);
        chk("rd_pending", q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
